// File: rtl/axis_skid_pipeline_if.sv
// AXI-Stream bundle shared by the skid pipeline's sink and source sides.
interface axis_skid_pipeline_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_skid_pipeline.sv
// Cascade of LENGTH two-entry skid buffers with registered tready; LENGTH=0 is a wire.
// Optional occupancy counter is built when AXIS_SKID_PIPELINE_STATUS_EN is defined.
module axis_skid_pipeline #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int LENGTH      = 2
) (
  input  logic clk,
  input  logic rst,
  axis_skid_pipeline_if.slave  s_axis,
  axis_skid_pipeline_if.master m_axis
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
  ,
  output logic [((LENGTH == 0) ? 1 : $clog2(2 * LENGTH + 1))-1:0] occupancy
`endif
);

  localparam int PW   = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam int KOFF = USER_WIDTH + 1;
  localparam int DOFF = USER_WIDTH + 1 + KEEP_WIDTH;

  logic [KEEP_WIDTH-1:0] in_keep;
  logic                  in_last;
  logic [USER_WIDTH-1:0] in_user;
  logic [PW-1:0]         in_payload;
  logic [PW-1:0]         out_payload;

  // Disabled sidebands are forced at the entry so every stage carries constants.
  assign in_keep    = (KEEP_ENABLE != 0) ? s_axis.tkeep : {KEEP_WIDTH{1'b1}};
  assign in_last    = (LAST_ENABLE != 0) ? s_axis.tlast : 1'b1;
  assign in_user    = (USER_ENABLE != 0) ? s_axis.tuser : {USER_WIDTH{1'b0}};
  assign in_payload = {s_axis.tdata, in_keep, in_last, in_user};

  assign m_axis.tuser = out_payload[USER_WIDTH-1:0];
  assign m_axis.tlast = out_payload[USER_WIDTH];
  assign m_axis.tkeep = out_payload[KOFF +: KEEP_WIDTH];
  assign m_axis.tdata = out_payload[DOFF +: DATA_WIDTH];

  if (LENGTH == 0) begin : g_bypass
    assign out_payload   = in_payload;
    assign m_axis.tvalid = s_axis.tvalid;
    assign s_axis.tready = m_axis.tready;
  end else begin : g_pipe
    logic [PW-1:0]   link_data [0:LENGTH];
    logic [LENGTH:0] link_valid;
    logic [LENGTH:0] link_ready;

    assign link_data[0]       = in_payload;
    assign link_valid[0]      = s_axis.tvalid;
    assign s_axis.tready      = link_ready[0];
    assign link_ready[LENGTH] = m_axis.tready;
    assign out_payload        = link_data[LENGTH];
    assign m_axis.tvalid      = link_valid[LENGTH];

    for (genvar k = 0; k < LENGTH; k++) begin : g_stage
      logic          ready_q, ready_d;
      logic          out_valid_q, out_valid_d;
      logic          tmp_valid_q, tmp_valid_d;
      logic [PW-1:0] out_data_q, out_data_d;
      logic [PW-1:0] tmp_data_q, tmp_data_d;
      logic          sink_valid;
      logic          dn_ready;

      assign sink_valid      = link_valid[k];
      assign dn_ready        = link_ready[k+1];
      assign link_ready[k]   = ready_q;
      assign link_valid[k+1] = out_valid_q;
      assign link_data[k+1]  = out_data_q;

      // Next-state of one skid stage: accept into output or temp, or refill output from temp.
      always_comb begin
        ready_d     = dn_ready | (~tmp_valid_q & (~out_valid_q | ~sink_valid));
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        tmp_valid_d = tmp_valid_q;
        tmp_data_d  = tmp_data_q;
        if (ready_q) begin
          if (dn_ready | ~out_valid_q) begin
            out_valid_d = sink_valid;
            out_data_d  = link_data[k];
          end else begin
            tmp_valid_d = sink_valid;
            tmp_data_d  = link_data[k];
          end
        end else if (dn_ready) begin
          out_valid_d = tmp_valid_q;
          out_data_d  = tmp_data_q;
          tmp_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
          tmp_valid_d = tmp_valid_q;
        end
      end

      // Control bits reset; payload registers are only qualified by their valid bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ready_q     <= 1'b0;
          out_valid_q <= 1'b0;
          tmp_valid_q <= 1'b0;
        end else begin
          ready_q     <= ready_d;
          out_valid_q <= out_valid_d;
          tmp_valid_q <= tmp_valid_d;
        end
        out_data_q <= out_data_d;
        tmp_data_q <= tmp_data_d;
      end
    end
  end

`ifdef AXIS_SKID_PIPELINE_STATUS_EN
  localparam int OW = (LENGTH == 0) ? 1 : $clog2(2 * LENGTH + 1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  logic          s_hs, m_hs;
  logic [OW-1:0] occ_q, occ_d;

  assign s_hs      = s_axis.tvalid & s_axis.tready;
  assign m_hs      = m_axis.tvalid & m_axis.tready;
  assign occupancy = occ_q;

  // Held-beat count: up on sink handshake, down on source handshake.
  always_comb begin
    occ_d = occ_q;
    if (s_hs & ~m_hs) begin
      occ_d = occ_q + OCC_ONE;
    end else if (~s_hs & m_hs) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= {OW{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_axis_skid_pipeline.sv
// Self-checking bench: LENGTH=2 main instance, LENGTH=0 bypass, and a sideband-disabled copy.
module tb_axis_skid_pipeline;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_user;
  logic       m_ready;

  int n_cmp = 0;
  int n_fail = 0;
  int n_rx = 0;
  int cyc = 0;
  bit check_lat = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         stamp;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       exp_sr;
    logic       exp_mv;
    logic [7:0] exp_md;
    int         exp_occ;
  } vec_t;
  vec_t vecs[11];

  axis_skid_pipeline_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) d_s ();
  axis_skid_pipeline_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) d_m ();
  axis_skid_pipeline_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) b_s ();
  axis_skid_pipeline_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) b_m ();
  axis_skid_pipeline_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) n_s ();
  axis_skid_pipeline_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) n_m ();

`ifdef AXIS_SKID_PIPELINE_STATUS_EN
  logic [2:0] d_occ;
  logic [0:0] b_occ;
  logic [2:0] n_occ;
`endif

  assign d_s.tvalid = s_valid;
  assign d_s.tdata  = s_data;
  assign d_s.tkeep  = 1'b1;
  assign d_s.tlast  = s_last;
  assign d_s.tuser  = s_user;
  assign d_m.tready = m_ready;

  assign b_s.tvalid = s_valid;
  assign b_s.tdata  = s_data;
  assign b_s.tkeep  = 1'b1;
  assign b_s.tlast  = s_last;
  assign b_s.tuser  = s_user;
  assign b_m.tready = m_ready;

  assign n_s.tvalid = s_valid;
  assign n_s.tdata  = {s_data, s_data};
  assign n_s.tkeep  = 2'b01;
  assign n_s.tlast  = s_last;
  assign n_s.tuser  = s_user;
  assign n_m.tready = m_ready;

  axis_skid_pipeline #(.DATA_WIDTH(8), .LENGTH(2)) u_dut (
    .clk(clk), .rst(rst), .s_axis(d_s), .m_axis(d_m)
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    , .occupancy(d_occ)
`endif
  );

  axis_skid_pipeline #(.DATA_WIDTH(8), .LENGTH(0)) u_byp (
    .clk(clk), .rst(rst), .s_axis(b_s), .m_axis(b_m)
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    , .occupancy(b_occ)
`endif
  );

  axis_skid_pipeline #(.DATA_WIDTH(16), .KEEP_ENABLE(0), .KEEP_WIDTH(2), .LAST_ENABLE(0), .LENGTH(2)) u_nsb (
    .clk(clk), .rst(rst), .s_axis(n_s), .m_axis(n_m)
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    , .occupancy(n_occ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and per-cycle checks, evaluated mid-cycle for the upcoming edge.
  task automatic monitor();
    beat_t b;
    chk("bypass_path", 32'({b_m.tvalid, b_s.tready, b_m.tlast, b_m.tuser, b_m.tdata}),
        32'({s_valid, m_ready, s_last, s_user, s_data}));
    if (rst) begin
      sb.delete();
      return;
    end
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    chk("occupancy", 32'(d_occ), 32'(sb.size()));
`endif
    if (d_m.tvalid) chk("valid_has_beat", 32'(sb.size() > 0), 32'd1);
    if (n_m.tvalid) chk("nsb_sideband", 32'({n_m.tkeep, n_m.tlast}), 32'd7);
    if (d_m.tvalid && m_ready && sb.size() > 0) begin
      b = sb.pop_front();
      chk("beat", 32'({d_m.tlast, d_m.tuser, d_m.tdata}), 32'({b.last, b.user, b.data}));
      if (check_lat) chk("latency", 32'(cyc - b.stamp), 32'd2);
      n_rx++;
    end
    if (s_valid && d_s.tready) begin
      b.data = s_data; b.last = s_last; b.user = s_user; b.stamp = cyc;
      sb.push_back(b);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
  endtask

  task automatic advance();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int rx_base;
    int sent;
    bit pending;
    logic [7:0] r;

    vecs[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 32'd0};
    vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 32'd1};
    vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 32'd2};
    vecs[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA0, 32'd3};
    vecs[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 32'd4};
    vecs[5]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 32'd4};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA0, 32'd4};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 32'd3};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 32'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 32'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'd0};

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset and release
    for (int i = 0; i < 2; i++) begin
      wait_neg();
      if (i == 1) begin
        chk("rst_s_ready", 32'(d_s.tready), 32'd0);
        chk("rst_m_valid", 32'(d_m.tvalid), 32'd0);
      end
      advance();
    end
    rst = 1'b0;
    wait_neg();
    chk("post_rst_s_ready_low", 32'(d_s.tready), 32'd0);
    chk("post_rst_m_valid", 32'(d_m.tvalid), 32'd0);
    advance();
    wait_neg();
    chk("post_rst_s_ready_high", 32'(d_s.tready), 32'd1);
    advance();

    // Streaming 0x01..0x10, exact latency and no bubbles
    check_lat = 1'b1;
    rx_base = n_rx;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i); s_last = (i == 16); s_user = s_data[0]; m_ready = 1'b1;
      wait_neg();
      chk("stream_s_ready", 32'(d_s.tready), 32'd1);
      advance();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_neg();
      advance();
    end
    check_lat = 1'b0;
    chk("stream_count", 32'(n_rx - rx_base), 32'd16);

    m_ready = 1'b0;
    wait_neg();
    advance();

    // Backpressure fill and release, table driven
    for (int i = 0; i < 11; i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd; s_last = 1'b0; s_user = vecs[i].sd[0];
      m_ready = vecs[i].mr;
      wait_neg();
      chk("tbl_s_ready", 32'(d_s.tready), 32'(vecs[i].exp_sr));
      chk("tbl_m_valid", 32'(d_m.tvalid), 32'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) chk("tbl_m_data", 32'(d_m.tdata), 32'(vecs[i].exp_md));
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
      chk("tbl_occupancy", 32'(d_occ), 32'(vecs[i].exp_occ));
`endif
      advance();
    end

    // Random stalls over 1000 beats
    rx_base = n_rx;
    sent = 0;
    pending = 1'b0;
    for (int c = 0; c < 20000 && (n_rx - rx_base) < 1000; c++) begin
      if (!pending) begin
        s_valid = 1'b0;
        if (sent < 1000 && $urandom_range(0, 9) < 7) begin
          r = 8'($urandom);
          s_data = r; s_user = r[0]; s_last = (sent % 8 == 7); s_valid = 1'b1;
          pending = 1'b1;
          sent++;
        end
      end
      m_ready = ($urandom_range(0, 9) < 6);
      wait_neg();
      if (s_valid && d_s.tready) pending = 1'b0;
      advance();
    end
    s_valid = 1'b0;
    chk("random_count", 32'(n_rx - rx_base), 32'd1000);

    // Reset with three beats held
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_neg();
      advance();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h31 + i); s_last = 1'b0; s_user = s_data[0];
      wait_neg();
      chk("pre_rst_s_ready", 32'(d_s.tready), 32'd1);
      advance();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    wait_neg();
    chk("pre_rst_m_valid", 32'(d_m.tvalid), 32'd1);
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    chk("pre_rst_occupancy", 32'(d_occ), 32'd3);
`endif
    advance();
    rst = 1'b0;
    wait_neg();
    chk("mid_rst_m_valid", 32'(d_m.tvalid), 32'd0);
    chk("mid_rst_s_ready_low", 32'(d_s.tready), 32'd0);
`ifdef AXIS_SKID_PIPELINE_STATUS_EN
    chk("mid_rst_occupancy", 32'(d_occ), 32'd0);
`endif
    advance();
    wait_neg();
    chk("mid_rst_s_ready_high", 32'(d_s.tready), 32'd1);
    advance();

    // Bypass instance: same-cycle data, tready follows downstream
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b0;
    wait_neg();
    chk("byp_data", 32'(b_m.tdata), 32'h5A);
    chk("byp_valid", 32'(b_m.tvalid), 32'd1);
    chk("byp_ready_low", 32'(b_s.tready), 32'd0);
    m_ready = 1'b1;
    #1;
    chk("byp_ready_high", 32'(b_s.tready), 32'd1);
    advance();
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_neg();
      advance();
    end
    chk("final_drained", 32'(d_m.tvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
